// File: rtl/game_clock_if.sv
// Control/status bundle between the game clock and its users (display formatter, game FSM).
// MW/TW must match the widths derived inside game_clock for the same MAX_MINUTES.
interface game_clock_if #(
  parameter int MW = 5,
  parameter int TW = 11
) ();
  logic          run;
  logic          clear;
  logic          down;
  logic          load;
  logic [MW-1:0] load_minutes;
  logic          finish;
  logic [TW-1:0] timer;
  logic [5:0]    seconds;
  logic [MW-1:0] minutes;
  logic          tick;
  logic          expired;
  logic [TW-1:0] best_timer;
  logic          best_valid;

  modport master (
    output run, clear, down, load, load_minutes, finish,
    input  timer, seconds, minutes, tick, expired, best_timer, best_valid
  );

  modport slave (
    input  run, clear, down, load, load_minutes, finish,
    output timer, seconds, minutes, tick, expired, best_timer, best_valid
  );
endinterface

// File: rtl/game_clock.sv
// Saturating up/down game timer with an internal one-second prescaler.
// Define GAME_CLOCK_BEST_EN to build the best (lowest) solve-time register.
module game_clock #(
  parameter int  TICK_DIV    = 50_000_000,
  parameter int  MAX_MINUTES = 30,
  localparam int MW          = $clog2(MAX_MINUTES + 1),
  localparam int TW          = $clog2(MAX_MINUTES * 60 + 1)
) (
  input  logic         clk,
  input  logic         reset,
  game_clock_if.slave  bus
);
  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW:0]    LIMIT_X  = (TW+1)'(MAX_MINUTES * 60);
  localparam logic [MW-1:0]  MAX_MIN  = MW'(MAX_MINUTES);

  logic [PW-1:0] r_pre;
  logic [5:0]    r_seconds;
  logic [MW-1:0] r_minutes;
  logic [TW-1:0] r_timer;
  logic          r_tick;
  logic          r_expired;

  logic [PW-1:0] w_pre_next;
  logic [5:0]    w_seconds_next;
  logic [MW-1:0] w_minutes_next;
  logic [TW-1:0] w_timer_next;
  logic          w_tick_next;
  logic          w_expired_next;

  logic          w_en;
  logic          w_sec_evt;
  logic [MW-1:0] w_load_min;
  logic [TW:0]   w_load_timer;
  logic [TW:0]   w_timer_x;
  logic [TW:0]   w_timer_up;
  logic [TW:0]   w_timer_dn;

  assign w_en         = bus.run & ~r_expired;
  assign w_sec_evt    = w_en && (r_pre == PRE_LAST);
  assign w_load_min   = (bus.load_minutes > MAX_MIN) ? MAX_MIN : bus.load_minutes;
  assign w_load_timer = (TW+1)'(w_load_min) * (TW+1)'(60);
  assign w_timer_x    = {1'b0, r_timer};
  assign w_timer_up   = w_timer_x + (TW+1)'(1);
  assign w_timer_dn   = w_timer_x - (TW+1)'(1);

  always_comb begin
    w_pre_next     = r_pre;
    w_seconds_next = r_seconds;
    w_minutes_next = r_minutes;
    w_timer_next   = r_timer;
    w_tick_next    = 1'b0;
    w_expired_next = r_expired;

    if (bus.clear) begin
      w_pre_next     = '0;
      w_seconds_next = '0;
      w_minutes_next = '0;
      w_timer_next   = '0;
      w_expired_next = 1'b0;
    end else if (bus.load) begin
      w_pre_next     = '0;
      w_seconds_next = '0;
      w_minutes_next = w_load_min;
      w_timer_next   = w_load_timer[TW-1:0];
      w_expired_next = 1'b0;
    end else if (w_sec_evt) begin
      w_pre_next = '0;
      if (bus.down) begin
        // Already at 0:00 (e.g. cleared then run down): flag without stepping.
        if (w_timer_x == '0) begin
          w_expired_next = 1'b1;
        end else begin
          w_tick_next  = 1'b1;
          w_timer_next = w_timer_dn[TW-1:0];
          if (r_seconds == 6'd0) begin
            w_seconds_next = 6'd59;
            w_minutes_next = r_minutes - MW'(1);
          end else begin
            w_seconds_next = r_seconds - 6'd1;
          end
          if (w_timer_dn == '0)
            w_expired_next = 1'b1;
        end
      end else begin
        if (w_timer_x >= LIMIT_X) begin
          w_expired_next = 1'b1;
        end else begin
          w_tick_next  = 1'b1;
          w_timer_next = w_timer_up[TW-1:0];
          if (r_seconds == 6'd59) begin
            w_seconds_next = 6'd0;
            w_minutes_next = r_minutes + MW'(1);
          end else begin
            w_seconds_next = r_seconds + 6'd1;
          end
          if (w_timer_up == LIMIT_X)
            w_expired_next = 1'b1;
        end
      end
    end else if (w_en) begin
      w_pre_next = r_pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre     <= '0;
      r_seconds <= '0;
      r_minutes <= '0;
      r_timer   <= '0;
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_pre     <= w_pre_next;
      r_seconds <= w_seconds_next;
      r_minutes <= w_minutes_next;
      r_timer   <= w_timer_next;
      r_tick    <= w_tick_next;
      r_expired <= w_expired_next;
    end
  end

  assign bus.timer   = r_timer;
  assign bus.seconds = r_seconds;
  assign bus.minutes = r_minutes;
  assign bus.tick    = r_tick;
  assign bus.expired = r_expired;

`ifdef GAME_CLOCK_BEST_EN
  logic [TW-1:0] r_best_timer;
  logic          r_best_valid;
  logic          w_best_take;

  // Compares against the registered (pre-step) time, so a coincident step is ignored.
  assign w_best_take = bus.finish && !bus.down && !r_expired &&
                       (!r_best_valid || (r_timer < r_best_timer));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best_timer <= '0;
      r_best_valid <= 1'b0;
    end else if (w_best_take) begin
      r_best_timer <= r_timer;
      r_best_valid <= 1'b1;
    end
  end

  assign bus.best_timer = r_best_timer;
  assign bus.best_valid = r_best_valid;
`else
  logic w_unused_finish;
  assign w_unused_finish = bus.finish;
  assign bus.best_timer  = '0;
  assign bus.best_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_game_clock.sv
// Self-checking bench for game_clock: vector table, directed corner sequences and a
// randomized run compared against a total-seconds reference model.
module tb_game_clock;
  localparam int TD    = 4;
  localparam int MAXM  = 2;
  localparam int MW    = 2;
  localparam int TW    = 7;
  localparam int LIMIT = MAXM * 60;
`ifdef GAME_CLOCK_BEST_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  game_clock_if #(.MW(MW), .TW(TW)) bus ();

  game_clock #(.TICK_DIV(TD), .MAX_MINUTES(MAXM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic drive(input bit run, input bit clr, input bit dn, input bit ld,
                       input int lm, input bit fin);
    bus.run          = run;
    bus.clear        = clr;
    bus.down         = dn;
    bus.load         = ld;
    bus.load_minutes = MW'(lm);
    bus.finish       = fin;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_count(input string tag, input int t, input bit tk, input bit ex);
    check({tag, ".timer"},   int'(bus.timer),   t);
    check({tag, ".minutes"}, int'(bus.minutes), t / 60);
    check({tag, ".seconds"}, int'(bus.seconds), t % 60);
    check({tag, ".tick"},    int'(bus.tick),    int'(tk));
    check({tag, ".expired"}, int'(bus.expired), int'(ex));
  endtask

  task automatic check_best(input string tag, input int b, input bit v);
    check({tag, ".best_timer"}, int'(bus.best_timer), BEST_EN ? b : 0);
    check({tag, ".best_valid"}, int'(bus.best_valid), BEST_EN ? int'(v) : 0);
  endtask

  // Reference model: whole game time held as one integer of seconds.
  int m_total, m_pre, m_best;
  bit m_exp, m_tick, m_bvalid;

  task automatic model_reset();
    m_total = 0; m_pre = 0; m_best = 0;
    m_exp = 0; m_tick = 0; m_bvalid = 0;
  endtask

  task automatic model_step();
    int lm;
    m_tick = 0;
    if (BEST_EN && bus.finish && !bus.down && !m_exp && (!m_bvalid || m_total < m_best)) begin
      m_best   = m_total;
      m_bvalid = 1;
    end
    lm = int'(bus.load_minutes);
    if (bus.clear) begin
      m_total = 0; m_pre = 0; m_exp = 0;
    end else if (bus.load) begin
      m_total = ((lm > MAXM) ? MAXM : lm) * 60;
      m_pre = 0; m_exp = 0;
    end else if (bus.run && !m_exp) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        if (bus.down) begin
          if (m_total == 0) m_exp = 1;
          else begin
            m_total--; m_tick = 1;
            if (m_total == 0) m_exp = 1;
          end
        end else begin
          if (m_total >= LIMIT) m_exp = 1;
          else begin
            m_total++; m_tick = 1;
            if (m_total == LIMIT) m_exp = 1;
          end
        end
      end else begin
        m_pre++;
      end
    end
  endtask

  typedef struct {
    bit run; bit clr; bit dn; bit ld; int lm; int n;
    int e_timer; bit e_tick; bit e_exp;
  } vec_t;

  vec_t vt[26];

  initial begin
    string tag;
    int seg_fail;
    vt[0]  = '{1,0,0,0,0,240,  60,1,0};
    vt[1]  = '{1,0,0,0,0,240, 120,1,1};
    vt[2]  = '{1,0,0,0,0, 40, 120,0,1};
    vt[3]  = '{0,1,0,0,0,  1,   0,0,0};
    vt[4]  = '{1,0,1,1,1,  1,  60,0,0};
    vt[5]  = '{1,0,1,0,0,  4,  59,1,0};
    vt[6]  = '{1,0,1,0,0,236,   0,1,1};
    vt[7]  = '{0,0,0,1,3,  1, 120,0,0};
    vt[8]  = '{1,0,1,0,0,  3, 120,0,0};
    vt[9]  = '{1,1,1,1,1,  1,   0,0,0};
    vt[10] = '{1,0,0,0,0,  3,   0,0,0};
    vt[11] = '{1,0,0,1,1,  1,  60,0,0};
    vt[12] = '{1,0,0,0,0,  2,  60,0,0};
    vt[13] = '{0,0,0,0,0, 20,  60,0,0};
    vt[14] = '{1,0,0,0,0,  1,  60,0,0};
    vt[15] = '{1,0,0,0,0,  1,  61,1,0};
    vt[16] = '{0,1,0,0,0,  1,   0,0,0};
    vt[17] = '{1,0,1,0,0,  3,   0,0,0};
    vt[18] = '{1,0,1,0,0,  1,   0,0,1};
    vt[19] = '{0,1,0,0,0,  1,   0,0,0};
    vt[20] = '{1,0,0,0,0,  3,   0,0,0};
    vt[21] = '{0,0,0,0,0,  1,   0,0,0};
    vt[22] = '{1,0,0,0,0,  1,   1,1,0};
    vt[23] = '{1,0,0,1,2,  1, 120,0,0};
    vt[24] = '{1,0,0,0,0,  4, 120,0,1};
    vt[25] = '{1,0,1,0,0,  8, 120,0,1};

    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cycles(3);
    check_count("reset", 0, 0, 0);
    check_best("reset", 0, 0);
    $display("[TB] reset state timer=%0d expired=%0d", bus.timer, bus.expired);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vt[i].run, vt[i].clr, vt[i].dn, vt[i].ld, vt[i].lm, 0);
      cycles(vt[i].n);
      tag = $sformatf("vec%0d", i);
      check_count(tag, vt[i].e_timer, vt[i].e_tick, vt[i].e_exp);
      $display("[TB] vec %0d: %0d cycles -> timer=%0d %0d:%0d tick=%0d expired=%0d",
               i, vt[i].n, bus.timer, bus.minutes, bus.seconds, bus.tick, bus.expired);
    end

    // Best-time sequence.
    drive(0, 1, 0, 0, 0, 0); cycles(1);
    drive(1, 0, 0, 0, 0, 0); cycles(200);
    check_count("best50", 50, 1, 0);
    drive(0, 0, 0, 0, 0, 1); cycles(1);
    check_best("best50", 50, 1);
    $display("[TB] finish at 50 -> best=%0d valid=%0d", bus.best_timer, bus.best_valid);
    drive(0, 1, 0, 0, 0, 0); cycles(1);
    check_best("best_clr", 50, 1);
    drive(1, 0, 0, 0, 0, 0); cycles(280);
    check_count("best70", 70, 1, 0);
    drive(0, 0, 0, 0, 0, 1); cycles(1);
    check_best("best70", 50, 1);
    $display("[TB] finish at 70 -> best=%0d valid=%0d", bus.best_timer, bus.best_valid);
    drive(0, 1, 0, 0, 0, 0); cycles(1);
    drive(1, 0, 0, 0, 0, 0); cycles(120);
    drive(0, 0, 0, 0, 0, 1); cycles(1);
    check_best("best30", 30, 1);
    $display("[TB] finish at 30 -> best=%0d valid=%0d", bus.best_timer, bus.best_valid);
    drive(1, 0, 0, 0, 0, 0); cycles(360);
    check_count("best_exp", 120, 1, 1);
    drive(0, 0, 0, 0, 0, 1); cycles(1);
    check_best("best_exp", 30, 1);
    $display("[TB] finish while expired -> best=%0d valid=%0d", bus.best_timer, bus.best_valid);

    // Asynchronous reset mid-count, checked before the next rising edge.
    drive(0, 1, 0, 0, 0, 0); cycles(1);
    drive(1, 0, 0, 0, 0, 0); cycles(50);
    check_count("pre_rst", 12, 0, 0);
    #2 reset = 1'b0;
    #1;
    check_count("async_rst", 0, 0, 0);
    check_best("async_rst", 0, 0);
    $display("[TB] async reset mid-count -> timer=%0d best_valid=%0d", bus.timer, bus.best_valid);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    cycles(2);
    reset = 1'b1;

    // Randomized run against the reference model.
    model_reset();
    seg_fail = n_fail;
    for (int c = 0; c < 4000; c++) begin
      bit dn;
      dn = bus.down;
      if ($urandom_range(299) == 0) dn = ~dn;
      drive($urandom_range(99) < 90, $urandom_range(599) == 0, dn,
            $urandom_range(399) == 0, int'($urandom_range(3)), $urandom_range(39) == 0);
      model_step();
      cycles(1);
      tag = $sformatf("rnd%0d", c);
      check({tag, ".timer"},      int'(bus.timer),      m_total);
      check({tag, ".minutes"},    int'(bus.minutes),    m_total / 60);
      check({tag, ".seconds"},    int'(bus.seconds),    m_total % 60);
      check({tag, ".tick"},       int'(bus.tick),       int'(m_tick));
      check({tag, ".expired"},    int'(bus.expired),    int'(m_exp));
      check({tag, ".best_timer"}, int'(bus.best_timer), m_best);
      check({tag, ".best_valid"}, int'(bus.best_valid), int'(m_bvalid));
      if ((c % 500) == 499) begin
        $display("[TB] random burst ending at cycle %0d: timer=%0d expired=%0d best=%0d, %0d new failures",
                 c, bus.timer, bus.expired, bus.best_timer, n_fail - seg_fail);
        seg_fail = n_fail;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
